// File: rtl/load_sequencer.sv
// Job-level controller for the operand input stage: buffers one N*N job of
// operand pairs, streams it LSB-first with load_en, then kicks init and reports done.
module load_sequencer #(
  parameter int D_W         = 8,
  parameter int N           = 2,
  parameter int XFER_CYCLES = 2*N+2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [D_W-1:0] s_x,
  input  logic [D_W-1:0] s_y,
  output logic           load_en,
  output logic           init,
  output logic           data_in_x,
  output logic           data_in_y,
  output logic           busy,
  output logic           done
);

  localparam int NN  = N*N;
  localparam int L   = NN*D_W;
  localparam int W_W = $clog2(NN);
  localparam int C_W = $clog2(L+1);
  localparam int B_W = $clog2(L);
  localparam int T_W = $clog2(XFER_CYCLES+1);

  localparam logic [W_W-1:0] W_LAST  = W_W'(NN-1);
  localparam logic [C_W-1:0] C_END   = C_W'(L);
  localparam logic [C_W-1:0] C_LE_LAST = C_W'(L-1);
  localparam logic [T_W-1:0] T_LAST  = T_W'(XFER_CYCLES-1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_STREAM, S_SETTLE, S_KICK, S_WAIT, S_DONE
  } state_t;

  state_t         state_q;
  logic [W_W-1:0] wcnt_q;
  logic [C_W-1:0] c_q;
  logic [T_W-1:0] tcnt_q;
  logic [L-1:0]   xbuf_q;
  logic [L-1:0]   ybuf_q;
  logic           s_ready_q, load_en_q, init_q, dx_q, dy_q, busy_q, done_q;

  // Entry k occupies bits [k*D_W +: D_W], so the flattened buffer is already
  // in serial order: stream bit b is simply buf[b].
  always_ff @(posedge clk) begin
    if (state_q == S_COLLECT && s_valid) begin
      for (int k = 0; k < NN; k++) begin
        if (wcnt_q == W_W'(k)) begin
          xbuf_q[k*D_W +: D_W] <= s_x;
          ybuf_q[k*D_W +: D_W] <= s_y;
        end
      end
    end
  end

  // Outputs are registered with the state: each branch sets the values the
  // outputs must carry in the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      c_q       <= '0;
      tcnt_q    <= '0;
      s_ready_q <= 1'b0;
      load_en_q <= 1'b0;
      init_q    <= 1'b0;
      dx_q      <= 1'b0;
      dy_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_COLLECT;
            wcnt_q    <= '0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (s_valid) begin
            if (wcnt_q == W_LAST) begin
              state_q   <= S_STREAM;
              wcnt_q    <= '0;
              c_q       <= '0;
              s_ready_q <= 1'b0;
              load_en_q <= 1'b1;
              dx_q      <= 1'b0;
              dy_q      <= 1'b0;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (c_q == C_END) begin
            state_q   <= S_SETTLE;
            c_q       <= '0;
            load_en_q <= 1'b0;
            dx_q      <= 1'b0;
            dy_q      <= 1'b0;
          end else begin
            // Bit presented at c+1 is bit c of the buffer: one cycle of lag
            // covers the input stage's IDLE->LOAD entry.
            c_q       <= c_q + 1'b1;
            load_en_q <= (c_q != C_LE_LAST);
            dx_q      <= xbuf_q[c_q[B_W-1:0]];
            dy_q      <= ybuf_q[c_q[B_W-1:0]];
          end
        end
        S_SETTLE: begin
          state_q <= S_KICK;
          init_q  <= 1'b1;
        end
        S_KICK: begin
          state_q <= S_WAIT;
          init_q  <= 1'b0;
          tcnt_q  <= '0;
        end
        S_WAIT: begin
          if (tcnt_q == T_LAST) begin
            state_q <= S_DONE;
            tcnt_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          s_ready_q <= 1'b0;
          load_en_q <= 1'b0;
          init_q    <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign load_en   = load_en_q;
  assign init      = init_q;
  assign data_in_x = dx_q;
  assign data_in_y = dy_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
